// File: rtl/constants_pkg.sv
// Shared constants, types and address helpers for the instruction cache.
package constants_pkg;

   localparam int unsigned ICLLEN       = 128;
   localparam int unsigned IC_NUM_LINES = 16;
   localparam int unsigned IC_OFFSET_W  = 4;

   typedef enum logic [1:0] {
      IC_IDLE = 2'd0,
      IC_MISS = 2'd1,
      IC_FILL = 2'd2
   } ic_state_t;

   // Line index of a byte address for a cache with 2**idx_w lines.
   function automatic logic [63:0] ic_index(input logic [63:0] addr, input int unsigned idx_w);
      return (addr >> IC_OFFSET_W) & ((64'd1 << idx_w) - 64'd1);
   endfunction

   // Tag of a byte address: everything above offset and index.
   function automatic logic [63:0] ic_tag(input logic [63:0] addr, input int unsigned idx_w);
      return addr >> (IC_OFFSET_W + idx_w);
   endfunction

endpackage

// File: rtl/instruction_bus.sv
// Line-fill bus between the instruction cache (consumer) and memory (producer).
interface instruction_bus #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 128
);
   logic              ldp;
   logic [ADDR_W-1:0] ldAddr;
   logic              ldr;
   logic [DATA_W-1:0] ldData;

   modport consumer (output ldp, output ldAddr, input ldr, input ldData);
   modport producer (input ldp, input ldAddr, output ldr, output ldData);
endinterface

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: one combinational read port, one write port, flush.
module icache_line_store #(
   parameter int unsigned NUM_LINES = 16,
   parameter int unsigned TAG_W     = 24,
   parameter int unsigned DATA_W    = 128,
   localparam int unsigned IDX_W    = $clog2(NUM_LINES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  rd_index,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [DATA_W-1:0] rd_data,
   input  logic              we,
   input  logic [IDX_W-1:0]  wr_index,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              flush
);

   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [DATA_W-1:0]    data_q [NUM_LINES];

   // Valid bits: reset and flush both clear; flush beats a coincident fill.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= '0;
      end else if (flush) begin
         valid_q <= '0;
      end else if (we) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; valid gates their use.
   always_ff @(posedge clk) begin
      if (we) begin
         tag_q[wr_index]  <= wr_tag;
         data_q[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache_consumer.sv
// Direct-mapped read-only instruction cache; fills lines over instruction_bus.
module icache_consumer
   import constants_pkg::*;
#(
   parameter int unsigned NUM_LINES = IC_NUM_LINES,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_valid,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic [31:0]       fetch_instr,
   input  logic              flush,
   instruction_bus.consumer  bus
);

   localparam int unsigned IDX_W = $clog2(NUM_LINES);
   localparam int unsigned TAG_W = ADDR_W - IC_OFFSET_W - IDX_W;

   ic_state_t         state_q, state_d;
   logic              ldp_q;
   logic [ADDR_W-1:0] miss_addr_q;
   logic              miss_latch;
   logic              fill_we;
   logic              hit;

   logic [IDX_W-1:0]  rd_index;
   logic [TAG_W-1:0]  rd_tag_cmp;
   logic              rd_valid;
   logic [TAG_W-1:0]  rd_tag;
   logic [ICLLEN-1:0] rd_data;
   logic [IDX_W-1:0]  wr_index;
   logic [TAG_W-1:0]  wr_tag;
   logic [31:0]       sel_word;

   assign rd_index   = IDX_W'(ic_index(64'(fetch_addr), IDX_W));
   assign rd_tag_cmp = TAG_W'(ic_tag(64'(fetch_addr), IDX_W));
   assign wr_index   = IDX_W'(ic_index(64'(miss_addr_q), IDX_W));
   assign wr_tag     = TAG_W'(ic_tag(64'(miss_addr_q), IDX_W));

   icache_line_store #(
      .NUM_LINES (NUM_LINES),
      .TAG_W     (TAG_W),
      .DATA_W    (ICLLEN)
   ) u_store (
      .clk      (clk),
      .rst      (rst),
      .rd_index (rd_index),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .we       (fill_we),
      .wr_index (wr_index),
      .wr_tag   (wr_tag),
      .wr_data  (bus.ldData),
      .flush    (flush)
   );

   assign hit      = rd_valid && (rd_tag == rd_tag_cmp);
   assign sel_word = rd_data[32*int'(fetch_addr[3:2]) +: 32];

   // State, registered request and line-aligned miss address.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IC_IDLE;
         ldp_q       <= 1'b0;
         miss_addr_q <= '0;
      end else begin
         state_q <= state_d;
         ldp_q   <= (state_d == IC_MISS);
         if (miss_latch) begin
            miss_addr_q <= {fetch_addr[ADDR_W-1:IC_OFFSET_W], IC_OFFSET_W'(0)};
         end
      end
   end

   // Next state, hit response and fill strobe.
   always_comb begin
      state_d     = state_q;
      miss_latch  = 1'b0;
      fill_we     = 1'b0;
      fetch_ready = 1'b0;
      fetch_instr = 32'h0;
      case (state_q)
         IC_IDLE: begin
            if (fetch_valid) begin
               if (hit) begin
                  fetch_ready = 1'b1;
                  fetch_instr = sel_word;
               end else begin
                  miss_latch = 1'b1;
                  state_d    = IC_MISS;
               end
            end
         end
         IC_MISS: begin
            if (bus.ldr) begin
               fill_we = 1'b1;
               state_d = IC_FILL;
            end
         end
         IC_FILL: begin
            // One quiet ldp cycle before any further request.
            state_d = IC_IDLE;
         end
         default: state_d = IC_IDLE;
      endcase
   end

   assign bus.ldp    = ldp_q;
   assign bus.ldAddr = miss_addr_q;

endmodule

// File: tb/tb_icache_consumer.sv
// Directed bench for icache_consumer: miss/fill timing, hits, conflict, flush, reset.
module tb_icache_consumer;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_valid;
   logic [31:0] fetch_addr;
   logic        fetch_ready;
   logic [31:0] fetch_instr;
   logic        flush;

   int checks   = 0;
   int failures = 0;

   localparam logic [127:0] LINE0 = 128'h00408093_00308093_00208093_00108093;

   instruction_bus #(.ADDR_W(32), .DATA_W(128)) bus_if ();

   icache_consumer #(.NUM_LINES(16), .ADDR_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_valid (fetch_valid),
      .fetch_addr  (fetch_addr),
      .fetch_ready (fetch_ready),
      .fetch_instr (fetch_instr),
      .flush       (flush),
      .bus         (bus_if.consumer)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory contents the producer returns for a line.
   function automatic logic [127:0] line_of(input logic [31:0] a);
      logic [31:0] base;
      base = {a[31:4], 4'h0} ^ 32'hA500_0013;
      if (a[31:4] == 28'h0) return LINE0;
      return {base ^ 32'h3, base ^ 32'h2, base ^ 32'h1, base};
   endfunction

   function automatic logic [31:0] word_of(input logic [31:0] a);
      logic [127:0] l;
      l = line_of(a);
      return l[32*int'(a[3:2]) +: 32];
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0; fetch_valid = 1'b0; flush = 1'b0;
      bus_if.ldr = 1'b0; bus_if.ldData = '0;
      tick();
      rst = 1'b1;
   endtask

   // Full miss sequence against a 1-cycle producer; hold = ldr cycles.
   task automatic do_miss(input logic [31:0] a, input int hold, input logic flush_at_ldr);
      fetch_valid = 1'b1; fetch_addr = a;
      #1 check("miss_c0_ready", 128'(fetch_ready), 128'(1'b0));
      check("miss_c0_instr", 128'(fetch_instr), 128'h0);
      tick();
      #1 check("miss_c1_ldp", 128'(bus_if.ldp), 128'(1'b1));
      check("miss_c1_ldaddr", 128'(bus_if.ldAddr), 128'({a[31:4], 4'h0}));
      tick();
      bus_if.ldr = 1'b1; bus_if.ldData = line_of(a); flush = flush_at_ldr;
      #1 check("miss_c2_ldp", 128'(bus_if.ldp), 128'(1'b1));
      tick();
      flush = 1'b0;
      if (hold < 2) bus_if.ldr = 1'b0;
      #1 check("fill_ldp", 128'(bus_if.ldp), 128'(1'b0));
      check("fill_ready", 128'(fetch_ready), 128'(1'b0));
      tick();
      bus_if.ldr = 1'b0;
      #1 check("relookup_ready", 128'(fetch_ready), 128'(!flush_at_ldr));
      check("relookup_instr", 128'(fetch_instr), flush_at_ldr ? 128'h0 : 128'(word_of(a)));
      check("relookup_ldp", 128'(bus_if.ldp), 128'(1'b0));
   endtask

   task automatic expect_hit(input string tag, input logic [31:0] a, input logic [31:0] exp);
      fetch_valid = 1'b1; fetch_addr = a;
      #1 check({tag, "_ready"}, 128'(fetch_ready), 128'(1'b1));
      check({tag, "_instr"}, 128'(fetch_instr), 128'(exp));
      check({tag, "_ldp"}, 128'(bus_if.ldp), 128'(1'b0));
      tick();
   endtask

   initial begin
      fetch_addr = 32'h0;
      @(negedge clk);
      do_reset();
      #1 check("rst_ldp", 128'(bus_if.ldp), 128'(1'b0));
      check("rst_ldaddr", 128'(bus_if.ldAddr), 128'h0);
      check("rst_ready", 128'(fetch_ready), 128'(1'b0));
      tick();

      // Basic fill of line 0, then hits on its other words.
      do_miss(32'h0, 1, 1'b0);
      check("basic_instr_const", 128'(fetch_instr), 128'h00108093);
      tick();
      expect_hit("hit_4", 32'h4, 32'h00208093);
      expect_hit("hit_c", 32'hC, 32'h00408093);
      expect_hit("hit_8", 32'h8, 32'h00308093);
      fetch_valid = 1'b0; tick();

      // Other index does not disturb line 0.
      do_miss(32'h14, 1, 1'b0);
      tick();
      expect_hit("hit_0_after_idx1", 32'h0, 32'h00108093);

      // Conflict on index 0.
      do_miss(32'h100, 1, 1'b0);
      tick();
      do_miss(32'h0, 1, 1'b0);
      tick();
      fetch_valid = 1'b0; tick();

      // Flush then re-miss.
      flush = 1'b1; tick(); flush = 1'b0;
      fetch_valid = 1'b1; fetch_addr = 32'h0;
      #1 check("flush_miss_ready", 128'(fetch_ready), 128'(1'b0));
      tick();
      #1 check("flush_miss_ldp", 128'(bus_if.ldp), 128'(1'b1));
      do_reset();

      // Flush coinciding with a hit keeps that hit.
      do_miss(32'h0, 1, 1'b0);
      tick();
      fetch_valid = 1'b1; fetch_addr = 32'h4; flush = 1'b1;
      #1 check("flush_hit_ready", 128'(fetch_ready), 128'(1'b1));
      check("flush_hit_instr", 128'(fetch_instr), 128'h00208093);
      tick(); flush = 1'b0;
      #1 check("after_flush_hit_ready", 128'(fetch_ready), 128'(1'b0));
      do_reset();

      // Flush at the fill edge: line stays invalid, second miss.
      do_miss(32'h0, 1, 1'b1);
      tick();
      #1 check("flush_ldr_second_ldp", 128'(bus_if.ldp), 128'(1'b1));
      do_reset();

      // Reset while ldp is high; late ldr must not fill.
      fetch_valid = 1'b1; fetch_addr = 32'h0;
      tick();
      #1 check("rstmid_ldp_before", 128'(bus_if.ldp), 128'(1'b1));
      do_reset();
      #1 check("rstmid_ldp_after", 128'(bus_if.ldp), 128'(1'b0));
      bus_if.ldr = 1'b1; bus_if.ldData = LINE0;
      tick();
      bus_if.ldr = 1'b0;
      fetch_valid = 1'b1; fetch_addr = 32'h0;
      #1 check("rstmid_still_miss", 128'(fetch_ready), 128'(1'b0));
      do_reset();

      // Producer holding ldr for two cycles: one fill, no duplicate request.
      do_miss(32'h20, 2, 1'b0);
      tick();
      fetch_valid = 1'b0;
      #1 check("held_ldp_idle", 128'(bus_if.ldp), 128'(1'b0));
      tick();
      expect_hit("held_hit_24", 32'h24, word_of(32'h24));
      #1 check("held_no_dup_ldp", 128'(bus_if.ldp), 128'(1'b0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog against a runaway bench.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/icache_consumer.md
Name: icache_consumer

Overview:
Direct-mapped, read-only instruction cache between the fetch stage and main memory.
- Serves 32-bit fetches from a line array in flops; a hit is answered in the same cycle.
- On a miss it acts as the consumer end of instruction_bus: it issues ldp with a line-aligned ldAddr, waits for ldr, and captures ldData (ICLLEN = 128 bits) into the indexed line.
- Also provides a whole-cache flush (invalidate) for fence.i.

Parameters:
- NUM_LINES, 16, number of cache lines; power of two, at least 2.
- ADDR_W, 32, fetch address width.
- ICLLEN, 128 (from constants_pkg), line width in bits; 4 instructions per line.

Ports:
- clk  in  1  clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-low reset; rst=0 at a posedge resets the block.
- fetch_valid  in  1  core requests the instruction at fetch_addr; held until fetch_ready.
- fetch_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- fetch_ready  out  1  fetch_instr is valid this cycle; the request completes.
- fetch_instr  out  32  instruction word.
- flush  in  1  single-cycle pulse; invalidates all lines.
- bus  instruction_bus.consumer  members: ldp out 1 (line request), ldAddr out ADDR_W (line-aligned address), ldr in 1 (data valid, one-cycle pulse), ldData in ICLLEN.

Behaviour:
- Address split:
  - word offset = addr[3:2]
  - index = addr[3+log2(NUM_LINES):4]
  - tag = remaining upper bits
- Storage: per line a valid bit, a tag and ICLLEN data bits. Word k of a line is ldData[32k+31:32k].
- Reset (rst=0 at posedge):
  - all valid bits cleared; state=IDLE.
  - ldp=0 and ldAddr=0 from the next cycle.
  - fetch_ready is combinational and therefore 0 while nothing is valid. fetch_instr=0 whenever fetch_ready=0.
  - Tag and data arrays are not reset.
- FSM states are IDLE, MISS and FILL.
  - IDLE, fetch_valid with hit: fetch_ready=1 combinationally in the same cycle, fetch_instr = the selected word; stay in IDLE.
  - IDLE, fetch_valid with miss: fetch_ready=0. Latch miss_addr={fetch_addr[ADDR_W-1:4],4'b0}; next state MISS.
  - MISS: ldp=1 (registered) and ldAddr=miss_addr, both stable for the whole state. When ldr=1 is sampled, write ldData, the tag and valid=1 into the line at that edge; next state FILL.
  - FILL: ldp=0; next state IDLE.
    - Guarantees ldp is low for at least one cycle between requests, so the producer (IDLE→SERVING on ldp) never sees a back-to-back request.
  - The re-lookup in IDLE then hits.
- Latency:
  - Hit: 0 cycles.
  - Miss against a 1-cycle-response producer: miss detected in cycle 0, ldp high in cycles 1-2, ldr in cycle 2, FILL in cycle 3, hit in cycle 4.
- ldr outside MISS is ignored; no array write happens.
- Flush:
  - flush=1 at a posedge clears all valid bits, in any state.
  - If it coincides with a fill write, flush wins and the filled line stays invalid. The FSM still proceeds MISS→FILL→IDLE.
  - A flush in the same cycle as a hit does not suppress that hit's fetch_ready.
- fetch_addr changing while in MISS or FILL is a protocol violation. The fill still uses miss_addr, and the re-lookup in IDLE uses the current address.
- Reset mid-MISS:
  - ldp drops the following cycle; the outstanding ldr pulse is ignored because the FSM is in IDLE.
  - The producer's stray SERVING cycle is tolerated.
- Conflict: an address with the same index and a different tag misses and overwrites the line. Direct-mapped, no replacement policy.

Decomposition:
- Add to constants_pkg:
  - ic_state_t enum {IC_IDLE, IC_MISS, IC_FILL}
  - IC_NUM_LINES
  - IC_OFFSET_W=4
  - helper functions ic_index() and ic_tag()
- ICLLEN already lives in constants_pkg.
- One natural sub-module: icache_line_store.
  - Valid, tag and data arrays with one read port and one write port, plus flush.
  - Flush-over-write priority is implemented there.
- icache_consumer contains the FSM, hit compare and word mux.

Test Plan:
- After reset, fetch_valid=1 at addr 0x0 (producer line 128'h00408093_00308093_00208093_00108093):
  - cycle 1: ldp=1, ldAddr=0x0.
  - cycle 2: ldr=1.
  - cycle 3: ldp=0.
  - cycle 4: fetch_ready=1, fetch_instr=0x00108093.
  - Exactly one ldr pulse over the whole sequence.
- After the fill:
  - addr 0x4 → same-cycle hit, 0x00208093.
  - addr 0xC → same-cycle hit, 0x00408093.
  - ldp stays 0 throughout.
- Conflict:
  - addr 0x100 (index 0, new tag) → miss with ldAddr=0x100.
  - Then addr 0x0 misses again with ldAddr=0x0.
- Flush:
  - Fill 0x0, pulse flush; addr 0x0 → miss, ldp=1 next cycle.
  - Variant: flush in the same cycle as ldr; the line stays invalid and a second miss occurs.
- Reset mid-MISS:
  - Drive rst=0 while ldp=1, then release.
  - ldp=0 after the reset edge; a late ldr causes no write.
  - addr 0x0 still misses.
- Held ldr:
  - A producer holding ldr=1 for 2 cycles causes exactly one fill.
  - ldp stays low in FILL and no duplicate request is issued.
